// File: rtl/conv_pkg.sv
// Shared constants for the 3x3 convolution scheduler and engine.
// Holds the kernel size and the scheduler state encodings.
package conv_pkg;

    localparam int KERNEL = 3;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CHECK    = 3'd1;
    localparam logic [2:0] S_ISSUE    = 3'd2;
    localparam logic [2:0] S_WAIT_ENG = 3'd3;
    localparam logic [2:0] S_ADVANCE  = 3'd4;
    localparam logic [2:0] S_FINISH   = 3'd5;

endpackage

// File: rtl/conv_addr_gen.sv
// Output-pixel row/col counters, latched job configuration and
// window/output address generation for the convolution scheduler.
// Ports: clk, reset_b; load_i latches cfg_*_i and clears counters;
// adv_i steps to the next output pixel (row-major); cfg_ok_o says
// the latched size fits a 3x3 kernel; last_o flags the final pixel;
// win_addr_o / out_addr_o are the current window / output addresses.
module conv_addr_gen
    import conv_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DIM_W  = 4
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              load_i,
    input  logic              adv_i,
    input  logic [DIM_W-1:0]  cfg_w_i,
    input  logic [DIM_W-1:0]  cfg_h_i,
    input  logic [ADDR_W-1:0] cfg_in_base_i,
    input  logic [ADDR_W-1:0] cfg_out_base_i,
    output logic              cfg_ok_o,
    output logic              last_o,
    output logic [ADDR_W-1:0] win_addr_o,
    output logic [ADDR_W-1:0] out_addr_o
);

    localparam int SW = ADDR_W + 2 * DIM_W;
    localparam logic [DIM_W-1:0] K = DIM_W'(KERNEL);

    logic [DIM_W-1:0]  w_q, h_q;
    logic [ADDR_W-1:0] in_q, out_q;
    logic [DIM_W-1:0]  row_q, row_d;
    logic [DIM_W-1:0]  col_q, col_d;
    logic [SW-1:0]     win_sum, out_sum;

    assign cfg_ok_o = (w_q >= K) && (h_q >= K);
    assign last_o   = (row_q == h_q - K) && (col_q == w_q - K);

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (load_i) begin
            row_d = '0;
            col_d = '0;
        end else if (adv_i) begin
            if (col_q < w_q - K) begin
                col_d = col_q + DIM_W'(1);
            end else begin
                col_d = '0;
                row_d = row_q + DIM_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            w_q   <= '0;
            h_q   <= '0;
            in_q  <= '0;
            out_q <= '0;
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
            if (load_i) begin
                w_q   <= cfg_w_i;
                h_q   <= cfg_h_i;
                in_q  <= cfg_in_base_i;
                out_q <= cfg_out_base_i;
            end
        end
    end

    // Computed wide, then truncated: address wrap is intentional.
    always_comb begin
        win_sum = SW'(in_q)
                + SW'(row_q) * SW'(w_q)
                + SW'(col_q);
        out_sum = SW'(out_q)
                + SW'(row_q) * SW'(w_q - (K - DIM_W'(1)))
                + SW'(col_q);
    end

    assign win_addr_o = win_sum[ADDR_W-1:0];
    assign out_addr_o = out_sum[ADDR_W-1:0];

endmodule

// File: rtl/conv_scheduler.sv
// Walks every output pixel of a 3x3/stride-1 convolution and hands
// one window at a time to the XNOR/popcount engine.
// Ports: start/abort control, cfg_* image geometry and bases,
// eng_go/eng_win_addr/eng_out_addr/eng_done engine handshake,
// busy/done/err job status.
module conv_scheduler
    import conv_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DIM_W  = 4
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              start,
    input  logic              abort,
    input  logic [DIM_W-1:0]  cfg_w,
    input  logic [DIM_W-1:0]  cfg_h,
    input  logic [ADDR_W-1:0] cfg_in_base,
    input  logic [ADDR_W-1:0] cfg_out_base,
    output logic              eng_go,
    output logic [ADDR_W-1:0] eng_win_addr,
    output logic [ADDR_W-1:0] eng_out_addr,
    input  logic              eng_done,
    output logic              busy,
    output logic              done,
    output logic              err
);

    logic [2:0] state_q, state_d;
    logic       err_q, err_d;
    logic       load, adv;
    logic       cfg_ok, last;

    conv_addr_gen #(
        .ADDR_W (ADDR_W),
        .DIM_W  (DIM_W)
    ) u_addr (
        .clk            (clk),
        .reset_b        (reset_b),
        .load_i         (load),
        .adv_i          (adv),
        .cfg_w_i        (cfg_w),
        .cfg_h_i        (cfg_h),
        .cfg_in_base_i  (cfg_in_base),
        .cfg_out_base_i (cfg_out_base),
        .cfg_ok_o       (cfg_ok),
        .last_o         (last),
        .win_addr_o     (eng_win_addr),
        .out_addr_o     (eng_out_addr)
    );

    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        load    = 1'b0;
        adv     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (cfg_ok) begin
                    state_d = S_ISSUE;
                end else begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_ISSUE:    state_d = S_WAIT_ENG;
            S_WAIT_ENG: begin
                if (eng_done) state_d = S_ADVANCE;
            end
            S_ADVANCE: begin
                adv     = 1'b1;
                state_d = last ? S_FINISH : S_ISSUE;
            end
            S_FINISH:   state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
        // Abort overrides everything outside IDLE, including eng_done.
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            err_d   = 1'b0;
            adv     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q <= S_IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    assign eng_go = (state_q == S_ISSUE);
    assign done   = (state_q == S_FINISH);
    assign err    = err_q;
    // FINISH already counts as idle so busy falls with the done pulse.
    assign busy   = (state_q != S_IDLE) && (state_q != S_FINISH);

endmodule

// File: tb/tb_conv_scheduler.sv
// Scoreboard bench for conv_scheduler with a simple engine model.
// Expected engine windows and job outcomes come from a pixel-loop model.
module tb_conv_scheduler;

    localparam int AW = 8;
    localparam int DW = 4;
    localparam int GO = 0;
    localparam int DN = 1;
    localparam int ER = 2;

    typedef struct {
        int        kind;
        logic [7:0] win;
        logic [7:0] out;
    } ev_t;

    logic          clk = 1'b0;
    logic          reset_b = 1'b0;
    logic          start = 1'b0;
    logic          abort_m = 1'b0;
    logic          abort_e = 1'b0;
    logic          abort;
    logic [DW-1:0] cfg_w = '0;
    logic [DW-1:0] cfg_h = '0;
    logic [AW-1:0] cfg_in_base = '0;
    logic [AW-1:0] cfg_out_base = '0;
    logic          eng_done = 1'b0;
    logic          eng_go;
    logic [AW-1:0] eng_win_addr;
    logic [AW-1:0] eng_out_addr;
    logic          busy;
    logic          done;
    logic          err;

    assign abort = abort_m | abort_e;

    ev_t exp_q[$];
    int  errors = 0;
    int  checks = 0;
    int  cyc = 0;
    int  lat = 3;
    bit  stray_en = 1'b0;
    int  abort_n = 0;
    int  eng_cnt = 0;
    int  start_cyc = 0;
    int  first_go_cyc = -1;
    int  last_err_cyc = -1;
    int  last_done_cyc = -1;
    int  last_eng_done_cyc = -1;

    conv_scheduler #(
        .ADDR_W (AW),
        .DIM_W  (DW)
    ) dut (
        .clk          (clk),
        .reset_b      (reset_b),
        .start        (start),
        .abort        (abort),
        .cfg_w        (cfg_w),
        .cfg_h        (cfg_h),
        .cfg_in_base  (cfg_in_base),
        .cfg_out_base (cfg_out_base),
        .eng_go       (eng_go),
        .eng_win_addr (eng_win_addr),
        .eng_out_addr (eng_out_addr),
        .eng_done     (eng_done),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic got(int kind, logic [7:0] w, logic [7:0] o);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind=%0d win=%h out=%h required none",
                     kind, w, o);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind ||
                (kind == GO && (e.win != w || e.out != o))) begin
                errors++;
                $display("FAIL event: got kind=%0d win=%h out=%h required kind=%0d win=%h out=%h",
                         kind, w, o, e.kind, e.win, e.out);
            end
        end
    endtask

    // Reference: one window per output pixel, row-major, 8-bit wrap.
    function automatic void push_model(int w, int h, logic [7:0] ib,
                                       logic [7:0] ob, int max_go);
        ev_t e;
        int  n;
        n = 0;
        if (w < 3 || h < 3) begin
            e.kind = ER; e.win = '0; e.out = '0;
            exp_q.push_back(e);
            return;
        end
        for (int r = 0; r <= h - 3; r++) begin
            for (int c = 0; c <= w - 3; c++) begin
                if (max_go < 0 || n < max_go) begin
                    e.kind = GO;
                    e.win  = 8'(int'(ib) + r * w + c);
                    e.out  = 8'(int'(ob) + r * (w - 2) + c);
                    exp_q.push_back(e);
                end
                n++;
            end
        end
        if (max_go < 0) begin
            e.kind = DN; e.win = '0; e.out = '0;
            exp_q.push_back(e);
        end
    endfunction

    // Monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_b) begin
                if (eng_go) begin
                    if (first_go_cyc < 0) first_go_cyc = cyc;
                    got(GO, eng_win_addr, eng_out_addr);
                end
                if (done) begin
                    last_done_cyc = cyc;
                    got(DN, 8'h00, 8'h00);
                end
                if (err) begin
                    last_err_cyc = cyc;
                    got(ER, 8'h00, 8'h00);
                end
            end
        end
    end

    // Engine model: replies lat cycles after eng_go.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_b && eng_go) begin
                eng_cnt++;
                if (stray_en) eng_done = 1'b1;
                @(posedge clk); #1;
                eng_done = 1'b0;
                repeat (lat - 1) begin
                    @(posedge clk); #1;
                end
                eng_done = 1'b1;
                last_eng_done_cyc = cyc;
                if (abort_n != 0 && eng_cnt == abort_n) abort_e = 1'b1;
                @(posedge clk); #1;
                eng_done = 1'b0;
                if (abort_e) begin
                    abort_e = 1'b0;
                    chk("abort_busy", int'(busy), 0);
                end
            end
        end
    end

    task automatic scramble();
        cfg_w        = DW'($urandom);
        cfg_h        = DW'($urandom);
        cfg_in_base  = AW'($urandom);
        cfg_out_base = AW'($urandom);
    endtask

    task automatic run_job(int w, int h, logic [7:0] ib, logic [7:0] ob,
                           bit spam, int max_go, bit with_abort);
        int i;
        push_model(w, h, ib, ob, max_go);
        eng_cnt = 0;
        first_go_cyc = -1;
        last_err_cyc = -1;
        last_done_cyc = -1;
        @(posedge clk); #1;
        cfg_w = DW'(w);
        cfg_h = DW'(h);
        cfg_in_base = ib;
        cfg_out_base = ob;
        start = 1'b1;
        abort_m = with_abort;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        abort_m = 1'b0;
        chk("busy_rise", int'(busy), 1);
        for (i = 0; i < 3000; i++) begin
            if (exp_q.size() == 0 && !busy) break;
            start = (spam && exp_q.size() > 1) ? 1'b1 : 1'b0;
            scramble();
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk("drain", exp_q.size(), 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int w, h;
        #2;
        chk("rst_busy", int'(busy), 0);
        chk("rst_go", int'(eng_go), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_win", int'(eng_win_addr), 0);
        chk("rst_out", int'(eng_out_addr), 0);
        repeat (2) @(posedge clk);
        #1 reset_b = 1'b1;
        repeat (2) @(posedge clk);

        lat = 3;
        run_job(5, 4, 8'h10, 8'h80, 0, -1, 0);
        chk("go_latency", first_go_cyc - start_cyc, 2);
        chk("go_count_5x4", eng_cnt, 6);

        run_job(2, 8, 8'h20, 8'h40, 0, -1, 0);
        chk("err_latency", last_err_cyc - start_cyc, 2);
        chk("err_no_go", eng_cnt, 0);
        chk("err_busy", int'(busy), 0);

        run_job(3, 3, 8'h33, 8'hC4, 0, -1, 0);
        chk("go_count_3x3", eng_cnt, 1);
        chk("done_latency", last_done_cyc - last_eng_done_cyc, 2);

        abort_n = 3;
        run_job(5, 4, 8'h10, 8'h80, 0, 3, 0);
        abort_n = 0;
        repeat (10) @(posedge clk);
        #1;
        chk("abort_go_count", eng_cnt, 3);
        chk("abort_no_done", last_done_cyc, -1);

        stray_en = 1'b1;
        run_job(5, 4, 8'h10, 8'h80, 1, -1, 0);
        stray_en = 1'b0;
        chk("spam_go_count", eng_cnt, 6);

        lat = 2;
        run_job(4, 4, 8'hFE, 8'h00, 0, -1, 0);

        run_job(3, 3, 8'h55, 8'h66, 0, -1, 1);
        chk("start_abort_go", eng_cnt, 1);

        // Reset in the middle of a job.
        push_model(5, 4, 8'h10, 8'h80, -1);
        eng_cnt = 0;
        @(posedge clk); #1;
        cfg_w = 4'd5; cfg_h = 4'd4;
        cfg_in_base = 8'h10; cfg_out_base = 8'h80;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 200 && eng_cnt < 2; i++) begin
            @(posedge clk); #1;
        end
        chk("mid_reset_reach", int'(eng_cnt >= 2), 1);
        reset_b = 1'b0;
        #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_go", int'(eng_go), 0);
        chk("mid_rst_win", int'(eng_win_addr), 0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 reset_b = 1'b1;
        repeat (10) @(posedge clk);
        run_job(4, 5, 8'hA0, 8'h20, 0, -1, 0);

        for (int j = 0; j < 20; j++) begin
            w = $urandom_range(0, 10);
            h = $urandom_range(0, 10);
            lat = $urandom_range(1, 4);
            stray_en = $urandom_range(0, 1) == 1;
            run_job(w, h, AW'($urandom), AW'($urandom),
                    $urandom_range(0, 1) == 1, -1, 0);
        end
        stray_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
